// File: rtl/rnic_exdes_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one AXIS TX stream between
// NUM_REQ requesters, with per-requester packet counters and error flags.
module rnic_exdes_tx_arbiter #(
  parameter int C_AXIS_DATA_WIDTH = 512,
  parameter int NUM_REQ           = 4,
  parameter int MAX_PKT_BEATS     = 64
) (
  input  logic                                 core_clk,
  input  logic                                 core_rst,
  input  logic                                 arb_enable,
  input  logic [NUM_REQ*C_AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_REQ*C_AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic [NUM_REQ-1:0]                   s_axis_tvalid,
  input  logic [NUM_REQ-1:0]                   s_axis_tlast,
  output logic [NUM_REQ-1:0]                   s_axis_tready,
  output logic [C_AXIS_DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]       m_axis_tkeep,
  output logic                                 m_axis_tvalid,
  output logic                                 m_axis_tlast,
  input  logic                                 m_axis_tready,
  output logic [$clog2(NUM_REQ)-1:0]           grant_id,
  output logic                                 busy,
  output logic [NUM_REQ*16-1:0]                pkt_cnt,
  output logic [NUM_REQ-1:0]                   keep_err,
  output logic [NUM_REQ-1:0]                   len_err
);

  localparam int DW = C_AXIS_DATA_WIDTH;
  localparam int KW = C_AXIS_DATA_WIDTH / 8;
  localparam int GW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_PKT_BEATS + 2);

  typedef enum logic {IDLE, XFER} state_t;

  state_t                state_q, state_d;
  logic [GW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]         grant_q, grant_d;
  logic [BW-1:0]         beat_cnt_q, beat_cnt_d;
  logic [NUM_REQ*16-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [NUM_REQ-1:0]    keep_err_q, keep_err_d;
  logic [NUM_REQ-1:0]    len_err_q, len_err_d;

  logic [DW-1:0] sel_data;
  logic [KW-1:0] sel_keep;
  logic          sel_valid;
  logic          sel_last;
  logic          found;
  logic [GW-1:0] winner;
  logic [GW:0]   cand;
  logic [GW:0]   nxt;
  logic [GW-1:0] nxt_ptr;
  logic          accept;

  always_comb begin
    sel_data  = '0;
    sel_keep  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == GW'(i)) begin
        sel_data  = s_axis_tdata[i*DW +: DW];
        sel_keep  = s_axis_tkeep[i*KW +: KW];
        sel_valid = s_axis_tvalid[i];
        sel_last  = s_axis_tlast[i];
      end
    end
  end

  // First valid requester at or above rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found  = 1'b0;
    winner = rr_ptr_q;
    cand   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (GW+1)'(k);
      if (cand >= (GW+1)'(NUM_REQ)) begin
        cand = cand - (GW+1)'(NUM_REQ);
      end
      if (!found && s_axis_tvalid[cand[GW-1:0]]) begin
        found  = 1'b1;
        winner = cand[GW-1:0];
      end
    end
  end

  always_comb begin
    nxt = {1'b0, grant_q} + 1'b1;
    if (nxt == (GW+1)'(NUM_REQ)) begin
      nxt = '0;
    end
    nxt_ptr = nxt[GW-1:0];
  end

  assign accept = (state_q == XFER) && sel_valid && m_axis_tready;

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_d       = grant_q;
    beat_cnt_d    = beat_cnt_q;
    pkt_cnt_d     = pkt_cnt_q;
    keep_err_d    = keep_err_q;
    len_err_d     = len_err_q;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = '0;
    unique case (state_q)
      IDLE: begin
        if (arb_enable && found) begin
          grant_d    = winner;
          beat_cnt_d = '0;
          state_d    = XFER;
        end
      end
      XFER: begin
        m_axis_tvalid          = sel_valid;
        m_axis_tlast           = sel_last;
        s_axis_tready[grant_q] = m_axis_tready;
        if (accept) begin
          if (beat_cnt_q != '1) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
          if (!sel_last) begin
            if (!(&sel_keep)) begin
              keep_err_d[grant_q] = 1'b1;
            end
            // beat_cnt_q counts beats already taken; this is beat MAX+1 or later
            if (beat_cnt_q >= BW'(MAX_PKT_BEATS)) begin
              len_err_d[grant_q] = 1'b1;
            end
          end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
              if (grant_q == GW'(i)) begin
                pkt_cnt_d[i*16 +: 16] = pkt_cnt_q[i*16 +: 16] + 16'd1;
              end
            end
            rr_ptr_d = nxt_ptr;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      beat_cnt_q <= '0;
      pkt_cnt_q  <= '0;
      keep_err_q <= '0;
      len_err_q  <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      beat_cnt_q <= beat_cnt_d;
      pkt_cnt_q  <= pkt_cnt_d;
      keep_err_q <= keep_err_d;
      len_err_q  <= len_err_d;
    end
  end

  assign m_axis_tdata = sel_data;
  assign m_axis_tkeep = sel_keep;
  assign grant_id     = grant_q;
  assign busy         = (state_q == XFER);
  assign pkt_cnt      = pkt_cnt_q;
  assign keep_err     = keep_err_q;
  assign len_err      = len_err_q;

endmodule

// File: tb/tb_rnic_exdes_tx_arbiter.sv
// Scoreboard bench for the TX arbiter: per-requester expected beats,
// grant order log, backpressure, error flags, enable gating, reset.
module tb_rnic_exdes_tx_arbiter;

  localparam int DW = 512;
  localparam int KW = 64;
  localparam int NR = 4;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
  } beat_t;

  logic             clk = 1'b0;
  logic             core_rst;
  logic             arb_enable;
  logic [NR*DW-1:0] s_tdata;
  logic [NR*KW-1:0] s_tkeep;
  logic [NR-1:0]    s_tvalid;
  logic [NR-1:0]    s_tlast;
  logic [NR-1:0]    s_tready;
  logic [DW-1:0]    m_tdata;
  logic [KW-1:0]    m_tkeep;
  logic             m_tvalid;
  logic             m_tlast;
  logic             m_tready;
  logic [1:0]       grant_id;
  logic             busy;
  logic [NR*16-1:0] pkt_cnt;
  logic [NR-1:0]    keep_err;
  logic [NR-1:0]    len_err;

  rnic_exdes_tx_arbiter #(
    .C_AXIS_DATA_WIDTH(DW),
    .NUM_REQ(NR),
    .MAX_PKT_BEATS(64)
  ) dut (
    .core_clk(clk),
    .core_rst(core_rst),
    .arb_enable(arb_enable),
    .s_axis_tdata(s_tdata),
    .s_axis_tkeep(s_tkeep),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tlast(s_tlast),
    .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata),
    .m_axis_tkeep(m_tkeep),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tlast(m_tlast),
    .m_axis_tready(m_tready),
    .grant_id(grant_id),
    .busy(busy),
    .pkt_cnt(pkt_cnt),
    .keep_err(keep_err),
    .len_err(len_err)
  );

  always #5 clk = ~clk;

  int         n_chk;
  int         n_pass;
  int         cyc;
  int         last_start;
  bit         chk_rdy;
  logic [1:0] exp_g;
  int         acc_cnt[NR];
  bit         first[NR];
  int         glog[$];
  beat_t      src_q[NR][$];
  beat_t      exp_q[NR][$];

  localparam logic [KW-1:0] ONES = '1;

  task automatic chk(input string tag, input logic [DW-1:0] got,
                     input logic [DW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [15:0] pk(input int r);
    return pkt_cnt[r*16 +: 16];
  endfunction

  function automatic int pending();
    int n = 0;
    for (int i = 0; i < NR; i++) n += exp_q[i].size();
    return n;
  endfunction

  task automatic send_pkt(input int r, input int n,
                          input logic [KW-1:0] kf, input logic [KW-1:0] kl);
    beat_t b;
    for (int j = 0; j < n; j++) begin
      for (int w = 0; w < DW/32; w++) b.d[w*32 +: 32] = $urandom;
      b.l = (j == n - 1);
      b.k = b.l ? kl : kf;
      src_q[r].push_back(b);
      exp_q[r].push_back(b);
    end
  endtask

  task automatic cycle();
    beat_t        b;
    beat_t        e;
    int           g;
    logic [NR-1:0] hs;
    for (int i = 0; i < NR; i++) begin
      if (src_q[i].size() > 0) begin
        b = src_q[i][0];
        s_tvalid[i]          = 1'b1;
        s_tdata[i*DW +: DW]  = b.d;
        s_tkeep[i*KW +: KW]  = b.k;
        s_tlast[i]           = b.l;
      end else begin
        s_tvalid[i] = 1'b0;
        s_tlast[i]  = 1'b0;
      end
    end
    #1;
    if (chk_rdy) begin
      chk("bp_grant", grant_id, exp_g);
      chk("bp_valid", m_tvalid, 1'b1);
      chk("bp_tready", s_tready, m_tready ? (4'b1 << exp_g) : 4'b0);
    end
    hs = s_tvalid & s_tready;
    if (m_tvalid && m_tready) begin
      g = int'(grant_id);
      chk("sb_nonempty", exp_q[g].size() != 0, 1'b1);
      if (exp_q[g].size() != 0) begin
        e = exp_q[g].pop_front();
        chk("tdata", m_tdata, e.d);
        chk("tkeep", m_tkeep, e.k);
        chk("tlast", m_tlast, e.l);
      end
      if (first[g]) begin
        glog.push_back(g);
        last_start = cyc;
      end
      first[g] = m_tlast;
      acc_cnt[g]++;
    end
    @(posedge clk);
    for (int i = 0; i < NR; i++) if (hs[i]) void'(src_q[i].pop_front());
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain(input int budget, output int n);
    n = 0;
    while (pending() > 0 && n < budget) begin
      cycle();
      n++;
    end
    chk("drain_done", pending(), 0);
  endtask

  task automatic chk_order(input int n, input logic [31:0] enc);
    chk("order_len", glog.size(), n);
    for (int i = 0; i < n && i < glog.size(); i++)
      chk("order", glog[i], enc[4*i +: 4]);
  endtask

  task automatic do_reset();
    core_rst = 1'b1;
    cycle();
    cycle();
    core_rst = 1'b0;
  endtask

  initial begin
    int            n;
    int            c0;
    bit            c64;
    bit            c65;
    logic [5:0]    pat;
    n_chk = 0; n_pass = 0; cyc = 0; last_start = 0;
    chk_rdy = 0; exp_g = '0;
    core_rst = 1'b1; arb_enable = 1'b1; m_tready = 1'b1;
    s_tdata = '0; s_tkeep = '0; s_tvalid = '0; s_tlast = '0;
    for (int i = 0; i < NR; i++) begin first[i] = 1; acc_cnt[i] = 0; end
    @(negedge clk);
    do_reset();
    chk("rst_busy", busy, 1'b0);
    chk("rst_grant", grant_id, 2'd0);
    chk("rst_mvalid", m_tvalid, 1'b0);
    chk("rst_sready", s_tready, 4'b0);
    chk("rst_pkt", pkt_cnt, 64'd0);
    chk("rst_errs", {keep_err, len_err}, 8'd0);

    // single requester, 3 beats
    send_pkt(2, 3, ONES, ONES);
    c0 = cyc;
    drain(20, n);
    chk("t1_latency", last_start - c0, 1);
    chk("t1_grant", grant_id, 2'd2);
    chk("t1_pkt2", pk(2), 16'd1);
    chk("t1_busy", busy, 1'b0);
    chk("t1_mvalid", m_tvalid, 1'b0);
    chk_order(1, 32'h2);

    // fairness: rr pointer back to 0 after reset
    do_reset();
    glog.delete();
    for (int r = 0; r < NR; r++) begin
      send_pkt(r, 2, ONES, ONES);
      send_pkt(r, 2, ONES, ONES);
    end
    drain(100, n);
    chk("t2_cycles", n, 24);
    chk_order(8, 32'h3210_3210);
    for (int r = 0; r < NR; r++) chk("t2_pkt", pk(r), 16'd2);

    // backpressure on req1 while req3 waits
    glog.delete();
    send_pkt(1, 4, ONES, ONES);
    send_pkt(3, 2, ONES, ONES);
    m_tready = 1'b1;
    cycle();
    pat = 6'b111_001;
    exp_g = 2'd1;
    for (int k = 0; k < 6; k++) begin
      m_tready = pat[k];
      chk_rdy = 1;
      cycle();
    end
    chk_rdy = 0;
    m_tready = 1'b1;
    chk("t3_req1_done", exp_q[1].size(), 0);
    drain(20, n);
    chk_order(2, 32'h31);

    // errors: partial keep on last beat is legal, on non-last is not
    send_pkt(2, 1, ONES, 64'h0FFF_FFFF_FFFF_FFFF);
    drain(10, n);
    chk("t4_keep_last_ok", keep_err, 4'b0000);
    send_pkt(0, 2, 64'h0FFF_FFFF_FFFF_FFFF, ONES);
    drain(10, n);
    chk("t4_keep_err", keep_err, 4'b0001);
    send_pkt(3, 66, ONES, ONES);
    acc_cnt[3] = 0; c64 = 0; c65 = 0; n = 0;
    while (exp_q[3].size() > 0 && n < 200) begin
      cycle();
      n++;
      if (acc_cnt[3] == 64 && !c64) begin
        chk("t4_len_b64", len_err, 4'b0000);
        c64 = 1;
      end
      if (acc_cnt[3] == 65 && !c65) begin
        chk("t4_len_b65", len_err, 4'b1000);
        c65 = 1;
      end
    end
    chk("t4_len_done", exp_q[3].size(), 0);
    send_pkt(1, 65, ONES, ONES);
    drain(200, n);
    chk("t4_len_65ok", len_err, 4'b1000);
    chk("t4_keep_sticky", keep_err, 4'b0001);

    // arb_enable drop mid-packet
    glog.delete();
    send_pkt(1, 4, ONES, ONES);
    cycle();
    cycle();
    arb_enable = 1'b0;
    send_pkt(2, 2, ONES, ONES);
    n = 0;
    while (exp_q[1].size() > 0 && n < 20) begin
      cycle();
      n++;
    end
    chk("t5_req1_done", exp_q[1].size(), 0);
    for (int k = 0; k < 3; k++) begin
      chk("t5_idle_busy", busy, 1'b0);
      chk("t5_idle_valid", m_tvalid, 1'b0);
      cycle();
    end
    chk("t5_req2_held", exp_q[2].size(), 2);
    arb_enable = 1'b1;
    c0 = cyc;
    drain(20, n);
    chk("t5_regrant", last_start - c0, 1);
    chk_order(2, 32'h21);

    // reset mid-packet
    send_pkt(0, 4, ONES, ONES);
    cycle();
    cycle();
    core_rst = 1'b1;
    m_tready = 1'b0;
    cycle();
    core_rst = 1'b0;
    m_tready = 1'b1;
    for (int i = 0; i < NR; i++) begin
      src_q[i].delete();
      exp_q[i].delete();
      first[i] = 1;
    end
    chk("t6_busy", busy, 1'b0);
    chk("t6_grant", grant_id, 2'd0);
    chk("t6_pkt", pkt_cnt, 64'd0);
    chk("t6_keep", keep_err, 4'b0);
    chk("t6_len", len_err, 4'b0);
    glog.delete();
    send_pkt(1, 1, ONES, ONES);
    drain(10, n);
    chk("t6_after_pkt1", pk(1), 16'd1);
    chk_order(1, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
